// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesting cores, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view of the bundle; the master modport is the view of the logic around it.
interface uart_tx_arbiter_if #(
    parameter int unsigned REQS = 4
);
    logic [REQS-1:0]   req_valid;
    logic [8*REQS-1:0] req_data;
    logic [REQS-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [4:0]        grant_id;
    logic              busy;

    modport slave (
        input  req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy
    );

    modport master (
        output req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets one core at a time stream bytes into a single UART transmitter.
// A grant ends on EOL_CHAR, after MAX_BURST bytes, or after IDLE_TIMEOUT consecutive stalled cycles.
module uart_tx_arbiter #(
    parameter int unsigned REQS         = 4,
    parameter int unsigned MAX_BURST    = 64,
    parameter logic [7:0]  EOL_CHAR     = 8'h0a,
    parameter int unsigned IDLE_TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset_n,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t     state_q, state_d;
    logic [4:0] grant_q, grant_d;
    logic [4:0] last_q, last_d;
    logic [7:0] byte_cnt_q, byte_cnt_d;
    logic [7:0] stall_q, stall_d;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       stage_free;
    logic       xfer;
    logic       rr_found_hi, rr_found_lo;
    logic [4:0] rr_hi, rr_lo;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            if (grant_q == i[4:0]) begin
                sel_valid = bus.req_valid[i];
                sel_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    assign stage_free = !tx_valid_q || bus.tx_ready;
    assign xfer       = (state_q == XFER) && sel_valid && stage_free;

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            bus.req_ready[i] = (state_q == XFER) && stage_free && (grant_q == i[4:0]);
        end
    end

    // Round-robin search split in two passes: indices above last_q win first, then wrap to the rest.
    always_comb begin
        rr_found_hi = 1'b0;
        rr_found_lo = 1'b0;
        rr_hi       = '0;
        rr_lo       = '0;
        for (int unsigned i = 0; i < REQS; i++) begin
            if (bus.req_valid[i]) begin
                if (i[4:0] > last_q) begin
                    if (!rr_found_hi) begin
                        rr_found_hi = 1'b1;
                        rr_hi       = i[4:0];
                    end
                end else if (!rr_found_lo) begin
                    rr_found_lo = 1'b1;
                    rr_lo       = i[4:0];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        stall_d    = stall_q;
        case (state_q)
            IDLE: begin
                if (rr_found_hi || rr_found_lo) begin
                    grant_d    = rr_found_hi ? rr_hi : rr_lo;
                    state_d    = XFER;
                    byte_cnt_d = '0;
                    stall_d    = '0;
                end
            end
            XFER: begin
                stall_d = sel_valid ? 8'd0 : stall_q + 8'd1;
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                end
                if ((xfer && (sel_data == EOL_CHAR || byte_cnt_q + 8'd1 == 8'(MAX_BURST))) ||
                    (!sel_valid && stall_q + 8'd1 == 8'(IDLE_TIMEOUT))) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= 5'(REQS - 1);
            byte_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // Output stage drains on its own, so a byte held at release still goes out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else if (xfer) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= sel_data;
        end else if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q == XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT and a message-level
// arbitration model predicts grant order, grant lengths and the transmitted byte stream.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned MB   = 64;
    localparam int unsigned TO   = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.REQS(NREQ)) bus ();

    uart_tx_arbiter #(
        .REQS(NREQ),
        .MAX_BURST(MB),
        .EOL_CHAR(8'h0a),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] src_q [NREQ][$];
    int         obs_grant[$];
    int         obs_len[$];
    logic [7:0] obs_bytes[$];
    int         exp_grant[$];
    int         exp_len[$];
    logic [7:0] exp_bytes[$];
    int         interleave_viol;
    int         stall_viol;
    int         stall_seen;
    bit         run_timeout;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_body();
        logic [7:0] b;
        b = 8'($urandom_range(0, 254));
        if (b == 8'h0a) b = 8'hff;
        return b;
    endfunction

    // Grants go round-robin among non-empty queues; each grant takes bytes until EOL,
    // MAX_BURST bytes, or the queue runs dry (which the DUT ends by timeout).
    function automatic void build_model();
        logic [7:0] m [NREQ][$];
        int last;
        int pick;
        int n;
        logic [7:0] b;
        exp_grant.delete();
        exp_len.delete();
        exp_bytes.delete();
        for (int i = 0; i < int'(NREQ); i++) m[i] = src_q[i];
        last = NREQ - 1;
        for (int guard = 0; guard < 10000; guard++) begin
            pick = -1;
            for (int k = 1; k <= int'(NREQ); k++) begin
                if (pick < 0 && m[(last + k) % NREQ].size() > 0) pick = (last + k) % NREQ;
            end
            if (pick < 0) break;
            n = 0;
            do begin
                b = m[pick].pop_front();
                exp_bytes.push_back(b);
                n++;
            end while (b != 8'h0a && n < int'(MB) && m[pick].size() > 0);
            exp_grant.push_back(pick);
            exp_len.push_back(n);
            last = pick;
        end
    endfunction

    // mode 0: tx_ready always 1; mode 1: random tx_ready; mode 2: tx_ready low for cycles 8..17
    task automatic run_stream(input int mode, input int max_cyc);
        logic [NREQ-1:0] hs;
        logic            txhs;
        logic [7:0]      txd;
        logic [7:0]      held;
        bit              prev_busy;
        bit              finished;
        bit              all_empty;
        obs_grant.delete();
        obs_len.delete();
        obs_bytes.delete();
        interleave_viol = 0;
        stall_viol      = 0;
        stall_seen      = 0;
        prev_busy       = 1'b0;
        finished        = 1'b0;
        held            = '0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            all_empty = 1'b1;
            for (int i = 0; i < int'(NREQ); i++) begin
                bus.req_valid[i]        = (src_q[i].size() > 0);
                bus.req_data[8*i +: 8]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
                if (src_q[i].size() > 0) all_empty = 1'b0;
            end
            case (mode)
                1:       bus.tx_ready = ($urandom_range(0, 3) != 0);
                2:       bus.tx_ready = !(c >= 8 && c < 18);
                default: bus.tx_ready = 1'b1;
            endcase
            #1;
            if (all_empty && !bus.busy && !bus.tx_valid) begin
                finished = 1'b1;
                break;
            end
            if (bus.busy && !prev_busy) begin
                obs_grant.push_back(int'(bus.grant_id));
                obs_len.push_back(0);
            end
            prev_busy = bus.busy;
            hs = bus.req_valid & bus.req_ready;
            for (int i = 0; i < int'(NREQ); i++) begin
                if (hs[i]) begin
                    if (!bus.busy || int'(bus.grant_id) != i || obs_len.size() == 0) interleave_viol++;
                    else obs_len[obs_len.size()-1] += 1;
                end
            end
            txhs = bus.tx_valid && bus.tx_ready;
            txd  = bus.tx_data;
            if (mode == 2 && c >= 8 && c < 18) begin
                if (c == 8) held = bus.tx_data;
                if (bus.tx_valid) stall_seen++;
                if (bus.tx_data !== held || bus.req_ready !== '0) stall_viol++;
            end
            @(posedge clk);
            for (int i = 0; i < int'(NREQ); i++) begin
                if (hs[i]) void'(src_q[i].pop_front());
            end
            if (txhs) obs_bytes.push_back(txd);
        end
        run_timeout   = !finished;
        bus.req_valid = '0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        bus.req_valid = '1;
        bus.req_data  = {8'h0a, 8'h0a, 8'h0a, 8'h0a};
        bus.tx_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %0b expected 0", bus.tx_valid); end
        n_checks++;
        if (bus.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h expected 00", bus.tx_data); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_checks++;
        if (bus.grant_id !== 5'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", bus.grant_id); end
        n_checks++;
        if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got busy=%0b grant=%0d expected busy=1 grant=0", bus.busy, bus.grant_id);
        end
        do_reset();
    endtask

    // scen 0: four "A\n"; 1: 100-byte burst on req 2; 2: tx_ready stall mid-grant;
    // 3: fairness with "\n" messages; 4+: random messages with random tx_ready
    task automatic test_stream(input string name, input int scen);
        int mode;
        int mism;
        int nmin;
        int nmsg;
        int len;
        do_reset();
        for (int i = 0; i < int'(NREQ); i++) src_q[i].delete();
        mode = 0;
        case (scen)
            0: for (int i = 0; i < int'(NREQ); i++) begin
                   src_q[i].push_back(8'h41);
                   src_q[i].push_back(8'h0a);
               end
            1: for (int k = 0; k < 100; k++) src_q[2].push_back(rand_body());
            2: begin
                   for (int k = 0; k < 30; k++) src_q[1].push_back(rand_body());
                   mode = 2;
               end
            3: for (int k = 0; k < 10; k++) begin
                   src_q[0].push_back(8'h0a);
                   src_q[1].push_back(8'h0a);
               end
            default: begin
                mode = 1;
                for (int i = 0; i < int'(NREQ); i++) begin
                    nmsg = $urandom_range(0, 3);
                    for (int m = 0; m < nmsg; m++) begin
                        len = $urandom_range(1, 8);
                        for (int k = 0; k < len - 1; k++) src_q[i].push_back(rand_body());
                        src_q[i].push_back(8'h0a);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        len = $urandom_range(1, 80);
                        for (int k = 0; k < len; k++) src_q[i].push_back(rand_body());
                    end
                end
            end
        endcase
        build_model();
        run_stream(mode, 3000);

        n_checks++;
        if (run_timeout !== 1'b0) begin n_fail++; $display("FAIL %s_completion: got timeout expected drained within cycle budget", name); end
        n_checks++;
        if (interleave_viol !== 0) begin n_fail++; $display("FAIL %s_interleave: got %0d foreign accepts expected 0", name, interleave_viol); end
        n_checks++;
        if (obs_grant.size() !== exp_grant.size()) begin
            n_fail++;
            $display("FAIL %s_grant_count: got %0d expected %0d", name, obs_grant.size(), exp_grant.size());
        end
        nmin = (obs_grant.size() < exp_grant.size()) ? obs_grant.size() : exp_grant.size();
        for (int k = 0; k < nmin; k++) begin
            n_checks++;
            if (obs_grant[k] !== exp_grant[k] || obs_len[k] !== exp_len[k]) begin
                n_fail++;
                $display("FAIL %s_grant[%0d]: got id=%0d len=%0d expected id=%0d len=%0d",
                         name, k, obs_grant[k], obs_len[k], exp_grant[k], exp_len[k]);
            end
        end
        n_checks++;
        if (obs_bytes.size() !== exp_bytes.size()) begin
            n_fail++;
            $display("FAIL %s_byte_count: got %0d expected %0d", name, obs_bytes.size(), exp_bytes.size());
        end
        nmin = (obs_bytes.size() < exp_bytes.size()) ? obs_bytes.size() : exp_bytes.size();
        mism = -1;
        for (int k = 0; k < nmin; k++) begin
            if (mism < 0 && obs_bytes[k] !== exp_bytes[k]) mism = k;
        end
        n_checks++;
        if (mism >= 0) begin
            n_fail++;
            $display("FAIL %s_byte_stream: byte %0d got %02h expected %02h", name, mism, obs_bytes[mism], exp_bytes[mism]);
        end
        if (scen == 2) begin
            n_checks++;
            if (stall_seen !== 10) begin n_fail++; $display("FAIL %s_held_valid: got %0d cycles expected 10", name, stall_seen); end
            n_checks++;
            if (stall_viol !== 0) begin n_fail++; $display("FAIL %s_hold: got %0d unstable cycles expected 0", name, stall_viol); end
        end
    endtask

    task automatic test_timeout();
        int n;
        int viol;
        do_reset();
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.req_data  = {8'h00, 8'h00, 8'h41, 8'h00};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.busy && n < 20);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 5'd1) begin
            n_fail++;
            $display("FAIL timeout_grant1: got busy=%0b grant=%0d expected busy=1 grant=1", bus.busy, bus.grant_id);
        end
        n_checks++;
        if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL timeout_ready: got %b expected 0010", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1000;
        bus.req_data  = {8'h33, 8'h00, 8'h00, 8'h00};
        n    = 0;
        viol = 0;
        while (bus.busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.busy && bus.req_ready[3]) viol++;
        end
        n_checks++;
        if (n !== int'(TO)) begin n_fail++; $display("FAIL timeout_release: got %0d stall cycles expected %0d", n, TO); end
        n_checks++;
        if (viol !== 0) begin n_fail++; $display("FAIL timeout_foreign_ready: got %0d cycles expected 0", viol); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 5'd3) begin
            n_fail++;
            $display("FAIL timeout_next_grant: got busy=%0b grant=%0d expected busy=1 grant=3", bus.busy, bus.grant_id);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid_grant();
        int n;
        do_reset();
        bus.tx_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data  = {8'h00, 8'h55, 8'h00, 8'h00};
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.busy && bus.tx_valid) && n < 20);
        n_checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h55 || bus.grant_id !== 5'd2) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got tx_valid=%0b data=%02h grant=%0d expected 1 55 2",
                     bus.tx_valid, bus.tx_data, bus.grant_id);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got tx_valid=%0b busy=%0b expected 0 0", bus.tx_valid, bus.busy);
        end
        n_checks++;
        if (bus.tx_data !== 8'h00 || bus.grant_id !== 5'd0 || bus.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got data=%02h grant=%0d ready=%b expected 00 0 0000",
                     bus.tx_data, bus.grant_id, bus.req_ready);
        end
        bus.req_valid = 4'b0101;
        bus.req_data  = {8'h00, 8'h55, 8'h00, 8'h0a};
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.grant_id !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mid_regrant: got busy=%0b grant=%0d expected busy=1 grant=0", bus.busy, bus.grant_id);
        end
        bus.req_valid = '0;
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_ready  = 1'b0;
        test_reset();
        test_stream("four_eol", 0);
        test_stream("max_burst", 1);
        test_stream("tx_stall", 2);
        test_timeout();
        test_reset_mid_grant();
        test_stream("fairness", 3);
        for (int r = 0; r < 4; r++) test_stream("random", 4 + r);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
